// File: rtl/serial_sub_ctrl.sv
// serial_sub_ctrl: streams two operands LSB-first into an external serial subtractor and captures its output.
// Optional abort input enabled by defining SERIAL_SUB_CTRL_ABORT_EN.
module serial_sub_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             start,
  output logic             ready,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             dp_clear_b,
  output logic             dp_shift,
  output logic             dp_sin,
  input  logic             dp_sout
`ifdef SERIAL_SUB_CTRL_ABORT_EN
  ,
  input  logic             abort
`endif
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  typedef enum logic [2:0] {IDLE, CLR, LOAD1, LOAD2, DRAIN, DONE} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [2*WIDTH-1:0] sh;
  logic last;
  logic ab;
  assign last = cnt == LAST;
`ifdef SERIAL_SUB_CTRL_ABORT_EN
  assign ab = abort && (state == CLR || state == LOAD1 || state == LOAD2 || state == DRAIN);
`else
  assign ab = 1'b0;
`endif
  // Both operands share one shift register; zeros shifted in give dp_sin=0 through DRAIN.
  always_ff @(posedge clk or posedge clear)
    if (clear) begin
      state <= IDLE;
      cnt <= '0;
      sh <= '0;
      ready <= 1'b1;
      busy <= 1'b0;
      done <= 1'b0;
      result <= '0;
      dp_clear_b <= 1'b1;
      dp_shift <= 1'b0;
      dp_sin <= 1'b0;
    end else if (ab) begin
      state <= IDLE;
      cnt <= '0;
      ready <= 1'b1;
      busy <= 1'b0;
      dp_clear_b <= 1'b0;
      dp_shift <= 1'b0;
      dp_sin <= 1'b0;
    end else
      case (state)
        IDLE: begin
          dp_clear_b <= !start;
          if (start) begin
            state <= CLR;
            sh <= {op2, op1};
            ready <= 1'b0;
            busy <= 1'b1;
          end
        end
        CLR: begin
          state <= LOAD1;
          cnt <= '0;
          dp_clear_b <= 1'b1;
          dp_shift <= 1'b1;
          dp_sin <= sh[0];
          sh <= sh >> 1;
        end
        LOAD1, LOAD2: begin
          dp_sin <= sh[0];
          sh <= sh >> 1;
          cnt <= last ? '0 : cnt + 1'b1;
          if (last) state <= (state == LOAD1) ? LOAD2 : DRAIN;
        end
        DRAIN: begin
          result <= {dp_sout, result[WIDTH-1:1]};
          cnt <= last ? '0 : cnt + 1'b1;
          if (last) begin
            state <= DONE;
            dp_shift <= 1'b0;
            done <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          done <= 1'b0;
          busy <= 1'b0;
          ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_serial_sub_ctrl.sv
// tb_serial_sub_ctrl: directed checks of stream order, capture, back-to-back, mid-run reset and abort.
module tb_serial_sub_ctrl;
  logic clk = 1'b0;
  logic clear, start, dp_sout;
  logic [3:0] op1, op2, result;
  logic ready, busy, done, dp_clear_b, dp_shift, dp_sin;
  int checks = 0;
  int errors = 0;
`ifdef SERIAL_SUB_CTRL_ABORT_EN
  logic abort = 1'b0;
`endif
  always #5 clk = ~clk;
  serial_sub_ctrl #(.WIDTH(4)) dut (
    .clk(clk), .clear(clear), .start(start), .ready(ready), .op1(op1), .op2(op2),
    .busy(busy), .done(done), .result(result), .dp_clear_b(dp_clear_b),
    .dp_shift(dp_shift), .dp_sin(dp_sin), .dp_sout(dp_sout)
`ifdef SERIAL_SUB_CTRL_ABORT_EN
    , .abort(abort)
`endif
  );
  task automatic chk(input string tag, input logic [3:0] got, exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $error("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic run(input logic [3:0] a, b, d, prev, input logic hold, pulse);
    logic [11:0] sq;
    logic [3:0] dq;
    sq = {4'b0000, b, a};
    dq = d;
    op1 = a;
    op2 = b;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    for (int c = 0; c < 14; c++) begin
      if (!hold) start = pulse && c == 5;
      op1 = ~a;
      op2 = ~b;
      dp_sout = (c >= 9 && c <= 12) ? dq[0] : 1'b0;
      if (c >= 9 && c <= 12) dq = dq >> 1;
      chk("ready", ready, 1'b0);
      chk("busy", busy, 1'b1);
      chk("clear_b", dp_clear_b, c != 0);
      chk("shift", dp_shift, c >= 1 && c <= 12);
      chk("sin", dp_sin, (c >= 1 && c <= 12) ? sq[0] : 1'b0);
      if (c >= 1 && c <= 12) sq = sq >> 1;
      chk("done", done, c == 13);
      if (c <= 9) chk("result_hold", result, prev);
      if (c < 13) begin
        @(posedge clk);
        @(negedge clk);
      end
    end
    chk("result", result, d);
    dp_sout = 1'b0;
  endtask
  initial begin
    clear = 1'b1;
    start = 1'b0;
    op1 = 4'h0;
    op2 = 4'h0;
    dp_sout = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_ready", ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_result", result, 4'h0);
    chk("rst_clear_b", dp_clear_b, 1'b1);
    chk("rst_shift", dp_shift, 1'b0);
    chk("rst_sin", dp_sin, 1'b0);
    clear = 1'b0;
    @(negedge clk);
    run(4'b1010, 4'b0011, 4'b1101, 4'b0000, 1'b0, 1'b0);
    @(negedge clk);
    chk("idle_ready", ready, 1'b1);
    chk("idle_busy", busy, 1'b0);
    chk("idle_done", done, 1'b0);
    chk("idle_clear_b", dp_clear_b, 1'b1);
    chk("idle_shift", dp_shift, 1'b0);
    @(negedge clk);
    chk("result_held", result, 4'b1101);
    run(4'hF, 4'h1, 4'b0110, 4'b1101, 1'b1, 1'b0);
    @(negedge clk);
    chk("b2b_ready", ready, 1'b1);
    chk("b2b_busy", busy, 1'b0);
    run(4'h3, 4'h5, 4'b1001, 4'b0110, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("noqueue_done", done, 1'b0);
      chk("noqueue_busy", busy, 1'b0);
      chk("noqueue_ready", ready, 1'b1);
    end
    op1 = 4'h6;
    op2 = 4'h9;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    clear = 1'b1;
    #1;
    chk("mid_rst_ready", ready, 1'b1);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_result", result, 4'h0);
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_done", done, 1'b0);
    chk("mid_rst_clear_b", dp_clear_b, 1'b1);
    chk("mid_rst_shift", dp_shift, 1'b0);
    chk("mid_rst_sin", dp_sin, 1'b0);
    clear = 1'b0;
    @(negedge clk);
    run(4'h6, 4'h9, 4'b0101, 4'b0000, 1'b0, 1'b0);
`ifdef SERIAL_SUB_CTRL_ABORT_EN
    @(negedge clk);
    run(4'h2, 4'h1, 4'b1111, 4'b0101, 1'b0, 1'b0);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    dp_sout = 1'b1;
    @(negedge clk);
    dp_sout = 1'b0;
    abort = 1'b1;
    @(posedge clk);
    @(negedge clk);
    abort = 1'b0;
    chk("abort_ready", ready, 1'b1);
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_clear_b", dp_clear_b, 1'b0);
    chk("abort_shift", dp_shift, 1'b0);
    chk("abort_result", result, 4'b1111);
    @(negedge clk);
    chk("abort_clear_b_rel", dp_clear_b, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_no_done", done, 1'b0);
    end
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
